// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if
//   Bundles the pipeline-side (p_*) and mem_system-side (m_*) signals of
//   mem_req_ctrl, plus the statistics counters.
//   slave  : the controller's view (takes p_* and m_rdata/done/stall/hit/err,
//            drives p_rdata/done, pipe_stall, mem_err, m_* and counters)
//   master : the environment's view (pipeline + mem_system), mirror image
interface mem_req_ctrl_if;
  logic        p_rd;
  logic        p_wr;
  logic [15:0] p_addr;
  logic [15:0] p_wdata;
  logic [15:0] p_rdata;
  logic        p_done;
  logic        pipe_stall;
  logic        mem_err;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_rdata;
  logic        m_done;
  logic        m_stall;
  logic        m_hit;
  logic        m_err;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  modport slave (
    input  p_rd, p_wr, p_addr, p_wdata, m_rdata, m_done, m_stall, m_hit, m_err,
    output p_rdata, p_done, pipe_stall, mem_err, m_addr, m_wdata, m_rd, m_wr,
           hit_cnt, miss_cnt
  );

  modport master (
    output p_rd, p_wr, p_addr, p_wdata, m_rdata, m_done, m_stall, m_hit, m_err,
    input  p_rdata, p_done, pipe_stall, mem_err, m_addr, m_wdata, m_rd, m_wr,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Sits between the pipeline MEM stage and mem_system (cache + banked memory).
//   Issues requests combinationally so cache hits finish in the issue cycle,
//   holds the request stable across multi-cycle misses while stalling the
//   pipeline, rejects misaligned / rd&wr requests, and aborts a request that
//   has not completed within TIMEOUT_CYCLES wait cycles.
// Ports
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : mem_req_ctrl_if.slave (pipeline p_*, mem_system m_*, hit/miss counters)
// Parameters
//   TIMEOUT_CYCLES : wait cycles without completion before ABORT
// Optional feature
//   MEM_REQ_STATS_EN : when defined, saturating hit/miss counters are built;
//                      otherwise hit_cnt/miss_cnt are constant zero.
module mem_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst,
  mem_req_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_t;

  state_t        r_state, w_nxt;
  logic          r_req_rd, r_req_wr;
  logic [15:0]   r_req_addr, r_req_wdata;
  logic [TW-1:0] r_tmo_cnt;

  logic        w_req, w_bad, w_fin, w_latch;
  logic        w_p_done, w_stall, w_err, w_m_rd, w_m_wr;
  logic [15:0] w_p_rdata, w_m_addr, w_m_wdata;

  // Stall/hit are informational only; completion is keyed on m_done.
  logic w_unused;
  assign w_unused = ^{bus.m_stall, bus.m_hit};

  assign w_req = bus.p_rd | bus.p_wr;
  assign w_bad = (bus.p_rd & bus.p_wr) | (w_req & bus.p_addr[0]);
  // A downstream error without done still ends the access.
  assign w_fin = bus.m_done | bus.m_err;

  always_comb begin
    w_nxt     = r_state;
    w_latch   = 1'b0;
    w_p_done  = 1'b0;
    w_stall   = 1'b0;
    w_err     = 1'b0;
    w_p_rdata = 16'h0000;
    w_m_rd    = 1'b0;
    w_m_wr    = 1'b0;
    w_m_addr  = 16'h0000;
    w_m_wdata = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_bad) begin
          // Rejected locally; never reaches mem_system.
          w_p_done = 1'b1;
          w_err    = 1'b1;
        end else if (w_req) begin
          w_m_rd    = bus.p_rd;
          w_m_wr    = bus.p_wr;
          w_m_addr  = bus.p_addr;
          w_m_wdata = bus.p_wdata;
          if (w_fin) begin
            w_p_done = 1'b1;
            w_err    = bus.m_err;
            if (bus.m_done && bus.p_rd) w_p_rdata = bus.m_rdata;
          end else begin
            w_stall = 1'b1;
            w_latch = 1'b1;
            w_nxt   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Replay the latched request; the pipeline may change p_* meanwhile.
        w_m_rd    = r_req_rd;
        w_m_wr    = r_req_wr;
        w_m_addr  = r_req_addr;
        w_m_wdata = r_req_wdata;
        if (w_fin) begin
          w_p_done = 1'b1;
          w_err    = bus.m_err;
          if (bus.m_done && r_req_rd) w_p_rdata = bus.m_rdata;
          w_nxt    = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) w_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        w_p_done = 1'b1;
        w_err    = 1'b1;
        w_nxt    = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_rd    <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_addr  <= 16'h0000;
      r_req_wdata <= 16'h0000;
      r_tmo_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_latch) begin
        r_req_rd    <= bus.p_rd;
        r_req_wr    <= bus.p_wr;
        r_req_addr  <= bus.p_addr;
        r_req_wdata <= bus.p_wdata;
        r_tmo_cnt   <= '0;
      end else if (r_state == S_WAIT && !w_fin) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign bus.p_done     = w_p_done;
  assign bus.pipe_stall = w_stall;
  assign bus.mem_err    = w_err;
  assign bus.p_rdata    = w_p_rdata;
  assign bus.m_rd       = w_m_rd;
  assign bus.m_wr       = w_m_wr;
  assign bus.m_addr     = w_m_addr;
  assign bus.m_wdata    = w_m_wdata;

`ifdef MEM_REQ_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  logic        w_hit, w_miss;

  // Hit = clean completion in the issue cycle; miss = clean completion from WAIT.
  assign w_hit  = w_p_done & ~w_err & (r_state == S_IDLE);
  assign w_miss = w_p_done & ~w_err & (r_state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 16'h0000;
      r_miss_cnt <= 16'h0000;
    end else begin
      if (w_hit && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`else
  assign bus.hit_cnt  = 16'h0000;
  assign bus.miss_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;
  localparam int TMO = 8;
`ifdef MEM_REQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus();

  mem_req_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An access is either outstanding (pending record + waited-cycle count),
  // being aborted, or absent. Expected outputs follow from that plus inputs.
  bit          md_pend = 0, md_abort = 0;
  bit          md_rd = 0, md_wr = 0;
  logic [15:0] md_addr = 0, md_wdata = 0;
  int          md_waited = 0, md_hits = 0, md_misses = 0;

  function automatic bit legal_req();
    return (bus.p_rd ^ bus.p_wr) && !bus.p_addr[0];
  endfunction

  always @(posedge clk) begin
    bit fin;
    fin = bus.m_done || bus.m_err;
    if (rst) begin
      md_pend = 0; md_abort = 0; md_hits = 0; md_misses = 0;
    end else if (md_abort) begin
      md_abort = 0;
    end else if (md_pend) begin
      if (fin) begin
        md_pend = 0;
        if (!bus.m_err && md_misses < 65535) md_misses++;
      end else begin
        md_waited++;
        if (md_waited == TMO) begin
          md_pend = 0;
          md_abort = 1;
        end
      end
    end else if (legal_req()) begin
      if (fin) begin
        if (!bus.m_err && md_hits < 65535) md_hits++;
      end else begin
        md_pend = 1; md_waited = 0;
        md_rd = bus.p_rd; md_wr = bus.p_wr;
        md_addr = bus.p_addr; md_wdata = bus.p_wdata;
      end
    end
  end

  always @(negedge clk) begin
    logic e_done, e_err, e_stall, e_mrd, e_mwr;
    logic [15:0] e_rdata, e_maddr, e_mwdata;
    if (chk_en) begin
      e_done = 0; e_err = 0; e_stall = 0; e_mrd = 0; e_mwr = 0;
      e_rdata = 0; e_maddr = 0; e_mwdata = 0;
      if (md_abort) begin
        e_done = 1; e_err = 1;
      end else if (md_pend) begin
        e_mrd = md_rd; e_mwr = md_wr; e_maddr = md_addr; e_mwdata = md_wdata;
        if (bus.m_done || bus.m_err) begin
          e_done = 1; e_err = bus.m_err;
          if (bus.m_done && md_rd) e_rdata = bus.m_rdata;
        end else e_stall = 1;
      end else if (bus.p_rd || bus.p_wr) begin
        if (!legal_req()) begin
          e_done = 1; e_err = 1;
        end else begin
          e_mrd = bus.p_rd; e_mwr = bus.p_wr; e_maddr = bus.p_addr; e_mwdata = bus.p_wdata;
          if (bus.m_done || bus.m_err) begin
            e_done = 1; e_err = bus.m_err;
            if (bus.m_done && bus.p_rd) e_rdata = bus.m_rdata;
          end else e_stall = 1;
        end
      end
      chk("mdl.p_done",     16'(bus.p_done),     16'(e_done));
      chk("mdl.mem_err",    16'(bus.mem_err),    16'(e_err));
      chk("mdl.pipe_stall", 16'(bus.pipe_stall), 16'(e_stall));
      chk("mdl.p_rdata",    bus.p_rdata,         e_rdata);
      chk("mdl.m_rd",       16'(bus.m_rd),       16'(e_mrd));
      chk("mdl.m_wr",       16'(bus.m_wr),       16'(e_mwr));
      chk("mdl.m_addr",     bus.m_addr,          e_maddr);
      chk("mdl.m_wdata",    bus.m_wdata,         e_mwdata);
      chk("mdl.hit_cnt",    bus.hit_cnt,  STATS ? 16'(md_hits)   : 16'h0);
      chk("mdl.miss_cnt",   bus.miss_cnt, STATS ? 16'(md_misses) : 16'h0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.p_rd = 0; bus.p_wr = 0; bus.p_addr = 0; bus.p_wdata = 0;
    bus.m_rdata = 0; bus.m_done = 0; bus.m_stall = 0; bus.m_hit = 0; bus.m_err = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    @(posedge clk); #1;
    chk_en = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst.pipe_stall", 16'(bus.pipe_stall), 16'h0);
    chk("rst.m_rd",       16'(bus.m_rd),       16'h0);
    chk("rst.p_done",     16'(bus.p_done),     16'h0);
    chk("rst.mem_err",    16'(bus.mem_err),    16'h0);
    tick();

    // 1: cold read miss, p_addr wanders while waiting
    bus.p_rd = 1; bus.p_addr = 16'h0010;
    @(negedge clk);
    chk("t1.stall_issue", 16'(bus.pipe_stall), 16'h1);
    chk("t1.m_addr_issue", bus.m_addr, 16'h0010);
    tick();
    bus.p_rd = 0; bus.p_addr = 16'h0044;
    @(negedge clk);
    chk("t1.m_addr_held", bus.m_addr, 16'h0010);
    chk("t1.m_rd_held", 16'(bus.m_rd), 16'h1);
    tick(); tick();
    bus.m_done = 1; bus.m_rdata = 16'hA5A5; bus.m_stall = 1;
    @(negedge clk);
    chk("t1.p_done", 16'(bus.p_done), 16'h1);
    chk("t1.p_rdata", bus.p_rdata, 16'hA5A5);
    chk("t1.stall_rel", 16'(bus.pipe_stall), 16'h0);
    tick();
    idle_in();
    @(negedge clk);
    chk("t1.miss_cnt", bus.miss_cnt, STATS ? 16'd1 : 16'd0);

    // 2: repeat read hits in the issue cycle
    tick();
    bus.p_rd = 1; bus.p_addr = 16'h0010; bus.m_done = 1; bus.m_hit = 1; bus.m_rdata = 16'hA5A5;
    @(negedge clk);
    chk("t2.p_done", 16'(bus.p_done), 16'h1);
    chk("t2.stall", 16'(bus.pipe_stall), 16'h0);
    chk("t2.p_rdata", bus.p_rdata, 16'hA5A5);
    tick();
    idle_in();
    @(negedge clk);
    chk("t2.hit_cnt", bus.hit_cnt, STATS ? 16'd1 : 16'd0);

    // 3: misaligned store, then rd&wr together
    tick();
    bus.p_wr = 1; bus.p_addr = 16'h0021; bus.p_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t3.mis_err", 16'(bus.mem_err), 16'h1);
    chk("t3.mis_done", 16'(bus.p_done), 16'h1);
    chk("t3.mis_m_wr", 16'(bus.m_wr), 16'h0);
    tick();
    bus.p_rd = 1; bus.p_wr = 1; bus.p_addr = 16'h0020;
    @(negedge clk);
    chk("t3.rw_err", 16'(bus.mem_err), 16'h1);
    chk("t3.rw_m_wr", 16'(bus.m_wr), 16'h0);
    chk("t3.rw_m_rd", 16'(bus.m_rd), 16'h0);
    tick();
    idle_in();
    tick();

    // 4: watchdog -- issue + TMO wait cycles stalled, then the abort cycle
    bus.p_rd = 1; bus.p_addr = 16'h0030;
    for (int i = 0; i <= TMO; i++) begin
      @(negedge clk);
      chk($sformatf("t4.stall%0d", i), 16'(bus.pipe_stall), 16'h1);
      tick();
    end
    @(negedge clk);
    chk("t4.abort_err", 16'(bus.mem_err), 16'h1);
    chk("t4.abort_done", 16'(bus.p_done), 16'h1);
    chk("t4.abort_m_rd", 16'(bus.m_rd), 16'h0);
    tick();
    idle_in();
    @(negedge clk);
    chk("t4.after_done", 16'(bus.p_done), 16'h0);
    tick();

    // 5: reset in the middle of WAIT
    bus.p_rd = 1; bus.p_addr = 16'h0040;
    tick(); tick();
    rst = 1; bus.p_rd = 0;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t5.m_rd", 16'(bus.m_rd), 16'h0);
    chk("t5.stall", 16'(bus.pipe_stall), 16'h0);
    chk("t5.hit_cnt", bus.hit_cnt, 16'h0);
    chk("t5.miss_cnt", bus.miss_cnt, 16'h0);
    tick();

    // 6: store miss then back-to-back load of the same word
    bus.p_wr = 1; bus.p_addr = 16'h0100; bus.p_wdata = 16'h1234;
    tick();
    @(negedge clk);
    chk("t6.m_wr", 16'(bus.m_wr), 16'h1);
    chk("t6.m_wdata", bus.m_wdata, 16'h1234);
    tick();
    bus.m_done = 1;
    @(negedge clk);
    chk("t6.st_rdata", bus.p_rdata, 16'h0000);
    tick();
    bus.m_done = 0; bus.p_wr = 0; bus.p_rd = 1; bus.p_wdata = 0;
    @(negedge clk);
    chk("t6.ld_issue", 16'(bus.m_rd), 16'h1);
    tick(); tick();
    bus.m_done = 1; bus.m_rdata = 16'h1234;
    @(negedge clk);
    chk("t6.ld_rdata", bus.p_rdata, 16'h1234);
    tick();
    idle_in();
    @(negedge clk);
    chk("t6.miss_cnt", bus.miss_cnt, STATS ? 16'd2 : 16'd0);
    tick();

    // downstream error while waiting ends the access with an error
    bus.p_rd = 1; bus.p_addr = 16'h0050;
    tick();
    bus.m_err = 1; bus.m_rdata = 16'h7777;
    @(negedge clk);
    chk("t7.err", 16'(bus.mem_err), 16'h1);
    chk("t7.done", 16'(bus.p_done), 16'h1);
    chk("t7.rdata", bus.p_rdata, 16'h0000);
    tick();
    idle_in();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
